lsu_arbiter: RTL and testbench
==============================

// Module: lsu_arbiter
// PURPOSE
//  Shares the single LSU port (data memory + I/O peripherals) between two requesters: core (ID 0) and DMA (ID 1).
//  Round-robin arbitration, one outstanding transaction at a time, fixed LSU read latency.
//  Rejects misaligned accesses without touching the LSU.
//  Sits between the core/DMA load-store paths and the lsu instance.
// PARAMETERS
//  RD_LATENCY  1  cycles from command presented to LSU until o_ld_data valid (0..3)
//  ADDR_W      32 address width
// PORTS
//  i_clk          in   1   clock; all state on rising edge
//  i_rst_n        in   1   reset, asynchronous, active-low
//  i_req[1:0]     in   2   request per requester; held with its command until gnt
//  i_addr0/1      in   32  address, requester 0/1
//  i_wdata0/1     in   32  store data
//  i_wren0/1      in   1   1 = store, 0 = load
//  i_sel_mod0/1   in   3   [1:0] BYTE=00 HWORD=01 WORD=10; [2] 1 = unsigned load
//  o_gnt[1:0]     out  2   one-hot, 1-cycle pulse: command accepted
//  o_rvalid[1:0]  out  2   one-hot, 1-cycle pulse: response for that requester
//  o_rdata        out  32  load data, valid with o_rvalid; 0 for stores/errors
//  o_err          out  1   valid with o_rvalid: misaligned access rejected
//  o_lsu_addr     out  32  to LSU i_lsu_addr
//  o_lsu_st_data  out  32  to LSU i_st_data
//  o_lsu_wren     out  1   to LSU i_lsu_wren
//  o_lsu_sel_mod  out  3   to LSU sel_mod
//  i_lsu_ld_data  in   32  from LSU o_ld_data
// BEHAVIOUR
//  Reset: state=IDLE; o_gnt, o_rvalid, o_err, o_lsu_wren = 0; o_rdata, o_lsu_addr, o_lsu_st_data = 0;
//   o_lsu_sel_mod = 3'b010; last_winner = 1 (core wins first tie).
//  FSM IDLE -> CMD -> WAIT -> RESP -> IDLE; ERR used for rejected requests.
//  IDLE: if any i_req: winner = sole requester, or on tie the one != last_winner.
//   o_gnt[winner]=1 combinationally this cycle; latch addr/wdata/wren/sel_mod/id; update last_winner.
//   Misaligned (WORD & addr[1:0]!=0, or HWORD & addr[0]!=0) -> ERR, else -> CMD.
//  CMD (1 cycle): LSU outputs driven from latched command; o_lsu_wren = latched wren only here.
//   RD_LATENCY==0: capture i_lsu_ld_data this cycle -> RESP. Else load counter -> WAIT.
//  WAIT: LSU outputs held, o_lsu_wren=0; count down; capture i_lsu_ld_data when count hits 0 -> RESP.
//  RESP (1 cycle): o_rvalid[id]=1, o_rdata = captured data (loads) or 0 (stores), o_err=0 -> IDLE.
//  ERR (1 cycle): no LSU access (o_lsu_wren stays 0); o_rvalid[id]=1, o_err=1, o_rdata=0 -> IDLE.
//  Latency, aligned access, req at cycle 0: gnt cycle 0, CMD cycle 1, rvalid cycle 2+RD_LATENCY.
//  Throughput: next gnt no earlier than the cycle after RESP/ERR; no gnt outside IDLE.
//  Requests arriving while busy wait; round-robin guarantees a waiting requester is served next.
//  o_lsu_* keep last command values in IDLE/RESP/ERR; only o_lsu_wren is forced 0 outside CMD.
//  Load data passed through unmodified (LSU does sign/zero extension).
//  Requester dropping i_req before gnt: ignored, no state change.
//  Reset mid-transaction: immediate return to reset state; in-flight response lost; requester reissues.
// STRUCTURE
//  lsu_pkg: sel_mod encodings (BYTE/HWORD/WORD), arb_state_e enum (IDLE,CMD,WAIT,RESP,ERR),
//   requester IDs (REQ_CORE=0, REQ_DMA=1), misalignment check function.
//  Sub-module rr_arb2: 2-way round-robin picker (i_req[1:0], i_last -> o_winner, o_valid), combinational.
//  Top: FSM, latency counter (2 bits), command/response registers.
// TESTING
//  Core LW 0x0000_0010, RD_LATENCY=1, LSU returns 0xDEADBEEF -> gnt[0] c0, wren=0, rvalid[0] c3, rdata=0xDEADBEEF.
//  DMA SW 0x0000_0800 data 0x7F -> o_lsu_wren=1 exactly 1 cycle, addr 0x800; rvalid[1], rdata=0, err=0.
//  Both req held continuously, 4 transactions -> grants alternate 0,1,0,1; no gnt while busy.
//  Core LW 0x0000_0002 -> err=1, rvalid[0] at c1, o_lsu_wren never asserted; HWORD 0x3 likewise.
//  Reset asserted during WAIT -> all outputs 0 async; no rvalid; next req after release served normally.
//  Sweep RD_LATENCY 0..3 -> rvalid at cycle 2+RD_LATENCY, data sampled on exact cycle (LSU changes data after).

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and the alignment rule for the LSU arbiter.
package lsu_pkg;
   localparam logic [1:0] SEL_BYTE  = 2'b00;
   localparam logic [1:0] SEL_HWORD = 2'b01;
   localparam logic [1:0] SEL_WORD  = 2'b10;
   localparam logic [2:0] SEL_RESET = {1'b0, SEL_WORD};
   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DMA  = 1'b1;

   typedef enum logic [2:0] {IDLE, CMD, WAIT, RESP, ERR} arb_state_e;

   function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] addr_lo);
      return (sel[1:0] == SEL_WORD && addr_lo != 2'b00) || (sel[1:0] == SEL_HWORD && addr_lo[0]);
   endfunction
endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; a tie goes to whoever did not win last.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_winner,
   output logic       o_valid
);
   assign o_valid  = |i_req;
   assign o_winner = &i_req ? ~i_last : i_req[1];
endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares the single LSU port between core and DMA, one transaction at a time.
module lsu_arbiter
   import lsu_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int ADDR_W     = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_req,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [31:0]       i_wdata0,
   input  logic [31:0]       i_wdata1,
   input  logic              i_wren0,
   input  logic              i_wren1,
   input  logic [2:0]        i_sel_mod0,
   input  logic [2:0]        i_sel_mod1,
   output logic [1:0]        o_gnt,
   output logic [1:0]        o_rvalid,
   output logic [31:0]       o_rdata,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_lsu_addr,
   output logic [31:0]       o_lsu_st_data,
   output logic              o_lsu_wren,
   output logic [2:0]        o_lsu_sel_mod,
   input  logic [31:0]       i_lsu_ld_data
);
   arb_state_e        state_q, state_d;
   logic              last_q, id_q, wren_q, win, win_valid, capture;
   logic [ADDR_W-1:0] addr_q, w_addr;
   logic [31:0]       wdata_q, rdata_q;
   logic [2:0]        sel_q, w_sel;
   logic [1:0]        cnt_q;

   rr_arb2 u_arb (.i_req(i_req), .i_last(last_q), .o_winner(win), .o_valid(win_valid));

   assign w_addr = win ? i_addr1 : i_addr0;
   assign w_sel  = win ? i_sel_mod1 : i_sel_mod0;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: state_d = !win_valid ? IDLE : misaligned(w_sel, w_addr[1:0]) ? ERR : CMD;
         CMD: begin
            capture = (RD_LATENCY == 0);
            state_d = capture ? RESP : WAIT;
         end
         WAIT: begin
            capture = (cnt_q == 2'd0);
            state_d = capture ? RESP : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_gnt         = (state_q == IDLE && win_valid) ? (win == REQ_DMA ? 2'b10 : 2'b01) : 2'b00;
   assign o_rvalid      = (state_q == RESP || state_q == ERR) ? (id_q == REQ_DMA ? 2'b10 : 2'b01) : 2'b00;
   assign o_err         = (state_q == ERR);
   assign o_rdata       = (state_q == RESP && !wren_q) ? rdata_q : 32'd0;
   assign o_lsu_addr    = addr_q;
   assign o_lsu_st_data = wdata_q;
   assign o_lsu_sel_mod = sel_q;
   assign o_lsu_wren    = (state_q == CMD) && wren_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         last_q  <= REQ_DMA;
         id_q    <= REQ_CORE;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= SEL_RESET;
         cnt_q   <= 2'd0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (o_gnt != 2'b00) begin
            last_q  <= win;
            id_q    <= win;
            wren_q  <= win ? i_wren1 : i_wren0;
            addr_q  <= w_addr;
            wdata_q <= win ? i_wdata1 : i_wdata0;
            sel_q   <= w_sel;
         end
         // CMD counts as the first latency cycle, so WAIT runs RD_LATENCY cycles
         if (state_q == CMD) cnt_q <= 2'(RD_LATENCY - 1);
         else if (state_q == WAIT) cnt_q <= cnt_q - 2'd1;
         if (capture) rdata_q <= i_lsu_ld_data;
      end
   end
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: four arbiters (RD_LATENCY 0..3) on shared stimulus, checked against a transaction-level model.
module tb_lsu_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, ld_data = 0;
   logic        wren0 = 0, wren1 = 0;
   logic [2:0]  sel0 = 3'b010, sel1 = 3'b010;

   logic [1:0]  gnt [4];
   logic [1:0]  rvalid [4];
   logic [31:0] rdata [4];
   logic [31:0] laddr [4];
   logic [31:0] lst [4];
   logic        err [4];
   logic        lwren [4];
   logic [2:0]  lsel [4];

   int n_cmp = 0, n_err = 0, cyc = 0, beef_cyc = -1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      lsu_arbiter #(.RD_LATENCY(g), .ADDR_W(32)) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
         .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
         .i_wren0(wren0), .i_wren1(wren1), .i_sel_mod0(sel0), .i_sel_mod1(sel1),
         .o_gnt(gnt[g]), .o_rvalid(rvalid[g]), .o_rdata(rdata[g]), .o_err(err[g]),
         .o_lsu_addr(laddr[g]), .o_lsu_st_data(lst[g]), .o_lsu_wren(lwren[g]),
         .o_lsu_sel_mod(lsel[g]), .i_lsu_ld_data(ld_data)
      );
   end

   always #5 clk = ~clk;

   // The LSU stand-in returns a per-cycle stamp so a capture on the wrong cycle shows up.
   always @(posedge clk) begin
      cyc++;
      #1;
      ld_data = (cyc == beef_cyc) ? 32'hDEAD_BEEF : (32'h5A00_0000 | 32'(cyc));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: busy window, response cycle and capture cycle from the latency rule.
   logic [31:0] ld_hist [2048];
   int          busy_until [4], resp_c [4], cmd_c [4], cap_c [4];
   logic        m_last [4], m_id [4], m_wren [4], m_err [4];
   logic [31:0] m_addr [4], m_wd [4];
   logic [2:0]  m_sel [4];
   logic [1:0]  e_gnt, e_rv;
   logic        e_err, e_we, win, hit;
   logic [31:0] e_rd;

   always @(negedge clk) begin
      ld_hist[cyc % 2048] = ld_data;
      for (int i = 0; i < 4; i++) begin
         if (!rst_n) begin
            busy_until[i] = 0; resp_c[i] = -1; cmd_c[i] = -1; cap_c[i] = 0;
            m_last[i] = 1'b1; m_id[i] = 1'b0; m_wren[i] = 1'b0; m_err[i] = 1'b0;
            m_addr[i] = 0; m_wd[i] = 0; m_sel[i] = 3'b010;
         end
         e_gnt = 2'b00;
         win = 1'b0;
         if (rst_n && cyc >= busy_until[i] && req != 2'b00) begin
            win = (req == 2'b11) ? !m_last[i] : req[1];
            e_gnt = win ? 2'b10 : 2'b01;
         end
         hit = rst_n && cyc == resp_c[i];
         e_rv = hit ? (m_id[i] ? 2'b10 : 2'b01) : 2'b00;
         e_err = hit && m_err[i];
         e_rd = (hit && !m_err[i] && !m_wren[i]) ? ld_hist[cap_c[i] % 2048] : 32'd0;
         e_we = rst_n && cyc == cmd_c[i] && !m_err[i] && m_wren[i];
         chk($sformatf("L%0d gnt", i), 32'(gnt[i]), 32'(e_gnt));
         chk($sformatf("L%0d rvalid", i), 32'(rvalid[i]), 32'(e_rv));
         chk($sformatf("L%0d err", i), 32'(err[i]), 32'(e_err));
         chk($sformatf("L%0d rdata", i), rdata[i], e_rd);
         chk($sformatf("L%0d lsu_wren", i), 32'(lwren[i]), 32'(e_we));
         chk($sformatf("L%0d lsu_addr", i), laddr[i], m_addr[i]);
         chk($sformatf("L%0d lsu_st_data", i), lst[i], m_wd[i]);
         chk($sformatf("L%0d lsu_sel_mod", i), 32'(lsel[i]), 32'(m_sel[i]));
         if (e_gnt != 2'b00) begin
            m_last[i] = win;
            m_id[i]   = win;
            m_addr[i] = win ? addr1 : addr0;
            m_wd[i]   = win ? wdata1 : wdata0;
            m_wren[i] = win ? wren1 : wren0;
            m_sel[i]  = win ? sel1 : sel0;
            m_err[i]  = (m_sel[i][1:0] == 2'b10 && m_addr[i][1:0] != 2'b00) ||
                        (m_sel[i][1:0] == 2'b01 && m_addr[i][0]);
            cmd_c[i] = cyc + 1;
            cap_c[i] = cyc + 1 + i;
            resp_c[i] = m_err[i] ? cyc + 1 : cyc + 2 + i;
            busy_until[i] = resp_c[i] + 1;
         end
      end
   end

   logic q_win [$];
   int   c0;

   initial begin
      repeat (2) tick();
      @(negedge clk);
      chk("reset gnt", 32'(gnt[1]), 32'd0);
      chk("reset sel_mod", 32'(lsel[1]), 32'h2);
      chk("reset lsu_addr", laddr[1], 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // core LW 0x10; LSU returns DEADBEEF on the L=1 capture cycle
      tick();
      beef_cyc = cyc + 2;
      req = 2'b01; addr0 = 32'h10; wren0 = 1'b0; sel0 = 3'b010;
      @(negedge clk);
      chk("lw gnt c0", 32'(gnt[1]), 32'h1);
      chk("lw wren c0", 32'(lwren[1]), 32'd0);
      tick();
      req = 2'b00;
      @(negedge clk);
      chk("lw addr c1", laddr[1], 32'h10);
      chk("lw wren c1", 32'(lwren[1]), 32'd0);
      tick(); tick();
      @(negedge clk);
      chk("lw rvalid c3", 32'(rvalid[1]), 32'h1);
      chk("lw rdata c3", rdata[1], 32'hDEAD_BEEF);
      repeat (6) tick();

      // DMA SW 0x800 <- 0x7F
      req = 2'b10; addr1 = 32'h800; wdata1 = 32'h7F; wren1 = 1'b1; sel1 = 3'b010;
      @(negedge clk);
      chk("sw gnt", 32'(gnt[1]), 32'h2);
      tick();
      req = 2'b00;
      @(negedge clk);
      chk("sw wren c1", 32'(lwren[1]), 32'h1);
      chk("sw addr c1", laddr[1], 32'h800);
      chk("sw data c1", lst[1], 32'h7F);
      tick();
      @(negedge clk);
      chk("sw wren c2", 32'(lwren[1]), 32'd0);
      tick();
      @(negedge clk);
      chk("sw rvalid", 32'(rvalid[1]), 32'h2);
      chk("sw rdata", rdata[1], 32'd0);
      chk("sw err", 32'(err[1]), 32'd0);
      repeat (6) tick();

      // both requesters held: grants must alternate starting with core
      wren1 = 1'b0; addr0 = 32'h20; addr1 = 32'h40;
      req = 2'b11;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (gnt[1] != 2'b00) q_win.push_back(gnt[1] == 2'b10);
         tick();
      end
      req = 2'b00;
      chk("rr grant count", 32'(q_win.size()), 32'd4);
      for (int k = 0; k < 4 && k < q_win.size(); k++)
         chk($sformatf("rr grant %0d", k), 32'(q_win[k]), 32'(k % 2));
      repeat (10) tick();

      // misaligned word, then misaligned halfword
      req = 2'b01; addr0 = 32'h2; sel0 = 3'b010;
      @(negedge clk);
      chk("misw gnt", 32'(gnt[1]), 32'h1);
      tick();
      req = 2'b00;
      @(negedge clk);
      chk("misw rvalid", 32'(rvalid[1]), 32'h1);
      chk("misw err", 32'(err[1]), 32'h1);
      chk("misw wren", 32'(lwren[1]), 32'd0);
      tick(); tick();
      req = 2'b01; addr0 = 32'h3; sel0 = 3'b001;
      tick();
      req = 2'b00;
      @(negedge clk);
      chk("mish rvalid", 32'(rvalid[3]), 32'h1);
      chk("mish err", 32'(err[3]), 32'h1);
      chk("mish wren", 32'(lwren[3]), 32'd0);
      repeat (3) tick();

      // reset during WAIT, then a normal DMA load
      req = 2'b01; addr0 = 32'h44; sel0 = 3'b010;
      tick();
      req = 2'b00;
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("rst rvalid", 32'(rvalid[1]), 32'd0);
      chk("rst addr", laddr[1], 32'd0);
      chk("rst rdata L0", rdata[0], 32'd0);
      chk("rst rvalid L0", 32'(rvalid[0]), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      c0 = cyc;
      req = 2'b10; addr1 = 32'h100; wren1 = 1'b0; sel1 = 3'b010;
      @(negedge clk);
      chk("post-rst gnt", 32'(gnt[1]), 32'h2);
      tick();
      req = 2'b00;
      tick(); tick();
      @(negedge clk);
      chk("post-rst rvalid", 32'(rvalid[1]), 32'h2);
      chk("post-rst rdata", rdata[1], 32'h5A00_0000 | 32'(c0 + 2));
      repeat (6) tick();

      // latency sweep: rvalid at 2+L, data from cycle 1+L
      c0 = cyc;
      req = 2'b01; addr0 = 32'h30; sel0 = 3'b010;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         for (int l = 0; l < 4; l++) begin
            chk($sformatf("sweep L%0d rvalid k%0d", l, k), 32'(rvalid[l]), (k == 2 + l) ? 32'h1 : 32'h0);
            if (k == 2 + l) chk($sformatf("sweep L%0d rdata", l), rdata[l], 32'h5A00_0000 | 32'(c0 + 1 + l));
         end
         tick();
         req = 2'b00;
      end
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
